// File: rtl/fp16_pkg.sv
// Purpose: shared FP16 field widths, special-value encodings and accumulator types.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fp16_pkg;

  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int BIAS  = 15;
  localparam int SIG_W = MAN_W + 1;   // significand with hidden bit
  localparam int ALN_W = SIG_W + 3;   // significand plus guard, round, sticky

  localparam logic [15:0] FP16_POS_INF = 16'h7C00;
  localparam logic [15:0] FP16_QNAN    = 16'h7E00;
  localparam logic [15:0] FP16_ZERO    = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_ADD   = 2'd2,
    ST_DONE  = 2'd3
  } fsm_state_t;

  // Registered hand-off between the align and add halves of the datapath.
  typedef struct packed {
    logic [EXP_W-1:0] exp_l;   // effective exponent of the larger operand
    logic [SIG_W-1:0] sig_l;   // significand of the larger operand
    logic [ALN_W-1:0] sig_s;   // aligned smaller significand with G/R/S
  } align_t;

endpackage

// File: rtl/fp16_nonneg_add_core.sv
// Purpose: combinational non-negative FP16 add, split into align and add/round halves.
// Latency: zero; the caller registers align_o before feeding it back as align_i.
// Backpressure: none, pure combinational datapath.
module fp16_nonneg_add_core
  import fp16_pkg::*;
(
  input  logic [14:0] a_mag,
  input  logic [14:0] b_mag,
  output align_t      align_o,
  input  align_t      align_i,
  output logic [14:0] sum_mag,
  output logic        sum_ovf
);

  logic [14:0]      l_mag, s_mag;
  logic [EXP_W-1:0] e_l, e_s, d;
  logic [SIG_W-1:0] sig_l, sig_s;
  logic [27:0]      wide;

  // Align: pick the larger magnitude and right-shift the smaller one with sticky collection.
  always_comb begin
    if (a_mag >= b_mag) begin
      l_mag = a_mag;
      s_mag = b_mag;
    end else begin
      l_mag = b_mag;
      s_mag = a_mag;
    end
    e_l   = (l_mag[14:10] == 5'd0) ? 5'd1 : l_mag[14:10];
    e_s   = (s_mag[14:10] == 5'd0) ? 5'd1 : s_mag[14:10];
    sig_l = {(l_mag[14:10] != 5'd0), l_mag[9:0]};
    sig_s = {(s_mag[14:10] != 5'd0), s_mag[9:0]};
    d     = e_l - e_s;
    wide  = {sig_s, 3'b000, 14'd0} >> d;
    align_o.exp_l = e_l;
    align_o.sig_l = sig_l;
    if (d >= 5'd14) begin
      align_o.sig_s = {13'd0, (sig_s != '0)};
    end else begin
      align_o.sig_s = wide[27:14] | {13'd0, (wide[13:0] != 14'd0)};
    end
  end

  logic [14:0] raw;
  logic [13:0] m;
  logic [5:0]  exp6;
  logic [5:0]  exp_f;
  logic        rnd;
  logic [15:0] res;

  // Add, renormalise a carry-out, round to nearest even and detect exponent overflow.
  always_comb begin
    raw = {1'b0, align_i.sig_l, 3'b000} + {1'b0, align_i.sig_s};
    if (raw[14]) begin
      m    = {raw[14:2], (raw[1] | raw[0])};
      exp6 = {1'b0, align_i.exp_l} + 6'd1;
    end else begin
      m    = raw[13:0];
      exp6 = {1'b0, align_i.exp_l};
    end
    // No hidden bit means both operands were denormal and the sum stayed denormal.
    exp_f = m[13] ? exp6 : 6'd0;
    rnd   = m[2] & (m[1] | m[0] | m[3]);
    // Rounding carry out of the mantissa ripples into the exponent naturally.
    res   = {exp_f, m[12:3]} + {15'd0, rnd};
    if (res[15:10] >= 6'd31) begin
      sum_mag = FP16_POS_INF[14:0];
      sum_ovf = 1'b1;
    end else begin
      sum_mag = res[14:0];
      sum_ovf = 1'b0;
    end
  end

endmodule

// File: rtl/fp16_sumsq_accumulator.sv
// Purpose: accumulates FRAME_LEN non-negative FP16 squares into one FP16 sum with ovf/nan flags.
// Latency: 3 cycles per sample (IDLE/ALIGN/ADD); sum valid 3 cycles after the last accept.
// Backpressure: in_ready low while a sample is in flight or a sum is held; DONE holds until out_ready.
module fp16_sumsq_accumulator
  import fp16_pkg::*;
#(
  parameter int FRAME_LEN = 4,
  parameter int CNT_W     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_ovf,
  output logic        out_nan
);

  fsm_state_t       state_q, state_d;
  logic [14:0]      opnd_q;
  logic [14:0]      acc_q, acc_d;
  logic [CNT_W-1:0] count_q;
  logic             ovf_q, nan_q;
  align_t           align_d, align_q;
  logic [14:0]      core_sum;
  logic             core_ovf;
  logic             ovf_hit;
  logic             last_smp;
  logic             opnd_nan, opnd_inf, acc_inf;
  logic             sign_unused;

  // Squares are non-negative, so the sign bit carries no information.
  assign sign_unused = in_data[15];

  assign last_smp = (count_q == CNT_W'(FRAME_LEN - 1));
  assign opnd_nan = (opnd_q[14:10] == 5'h1F) && (opnd_q[9:0] != 10'd0);
  assign opnd_inf = (opnd_q[14:10] == 5'h1F) && (opnd_q[9:0] == 10'd0);
  assign acc_inf  = (acc_q[14:10] == 5'h1F);

  fp16_nonneg_add_core u_core (
    .a_mag   (opnd_q),
    .b_mag   (acc_q),
    .align_o (align_d),
    .align_i (align_q),
    .sum_mag (core_sum),
    .sum_ovf (core_ovf)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: one sample walks IDLE->ALIGN->ADD, the last one parks in DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (in_valid) state_d = ST_ALIGN;
      ST_ALIGN: state_d = ST_ADD;
      ST_ADD:   state_d = last_smp ? ST_DONE : ST_IDLE;
      ST_DONE:  if (out_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output decode: the accumulator and sticky flags are shown directly and are frozen in DONE.
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    out_data  = {1'b0, acc_q};
    out_ovf   = ovf_q;
    out_nan   = nan_q;
  end

  // Special values override the finite datapath result; NaN dominates Inf.
  always_comb begin
    acc_d   = core_sum;
    ovf_hit = 1'b0;
    if (nan_q || opnd_nan) begin
      acc_d = FP16_QNAN[14:0];
    end else if (acc_inf || opnd_inf) begin
      acc_d = FP16_POS_INF[14:0];
    end else begin
      ovf_hit = core_ovf;
    end
  end

  // Datapath registers: operand capture, align stage, accumulator, counter and sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opnd_q  <= '0;
      align_q <= '0;
      acc_q   <= FP16_ZERO[14:0];
      count_q <= '0;
      ovf_q   <= 1'b0;
      nan_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) opnd_q <= in_data[14:0];
        end
        ST_ALIGN: begin
          align_q <= align_d;
        end
        ST_ADD: begin
          acc_q   <= acc_d;
          count_q <= count_q + CNT_W'(1);
          ovf_q   <= ovf_q | ovf_hit;
          nan_q   <= nan_q | opnd_nan;
        end
        ST_DONE: begin
          if (out_ready) begin
            acc_q   <= FP16_ZERO[14:0];
            count_q <= '0;
            ovf_q   <= 1'b0;
            nan_q   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_sumsq_accumulator.sv
module tb_fp16_sumsq_accumulator;

  logic        clk;
  logic        rst_n;
  logic        in_valid  [3];
  logic        in_ready  [3];
  logic [15:0] in_data   [3];
  logic        out_valid [3];
  logic        out_ready [3];
  logic [15:0] out_data  [3];
  logic        out_ovf   [3];
  logic        out_nan   [3];

  int checks;
  int errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: FRAME_LEN=4, instance 1: FRAME_LEN=2, instance 2: FRAME_LEN=3.
  fp16_sumsq_accumulator #(.FRAME_LEN(4), .CNT_W(16)) u_fl4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .out_ovf(out_ovf[0]), .out_nan(out_nan[0])
  );

  fp16_sumsq_accumulator #(.FRAME_LEN(2), .CNT_W(16)) u_fl2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .out_ovf(out_ovf[1]), .out_nan(out_nan[1])
  );

  fp16_sumsq_accumulator #(.FRAME_LEN(3), .CNT_W(16)) u_fl3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]),
    .out_ovf(out_ovf[2]), .out_nan(out_nan[2])
  );

  task automatic send(input int i, input logic [15:0] d);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready[i] && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL send_ready inst=%0d: in_ready=%b after %0d cycles, required 1", i, in_ready[i], n);
    end
    in_valid[i] = 1'b1;
    in_data[i]  = d;
    @(posedge clk);
    #1;
    in_valid[i] = 1'b0;
    in_data[i]  = 16'h0000;
  endtask

  task automatic collect(input int i, input logic [15:0] ed, input logic eo, input logic en,
                         input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid[i] && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL %s_valid: out_valid=%b, required 1", name, out_valid[i]);
    end
    checks++;
    if (out_data[i] !== ed) begin
      errors++;
      $display("FAIL %s_data: got %h, required %h", name, out_data[i], ed);
    end
    checks++;
    if (out_ovf[i] !== eo) begin
      errors++;
      $display("FAIL %s_ovf: got %b, required %b", name, out_ovf[i], eo);
    end
    checks++;
    if (out_nan[i] !== en) begin
      errors++;
      $display("FAIL %s_nan: got %b, required %b", name, out_nan[i], en);
    end
    out_ready[i] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[i] = 1'b0;
    checks++;
    if (out_valid[i] !== 1'b0 || in_ready[i] !== 1'b1 || out_data[i] !== 16'h0000) begin
      errors++;
      $display("FAIL %s_clear: valid=%b ready=%b data=%h, required 0 1 0000",
               name, out_valid[i], in_ready[i], out_data[i]);
    end
  endtask

  task automatic run_frame(input int i, input logic [15:0] s0, input logic [15:0] s1,
                           input logic [15:0] s2, input logic [15:0] s3, input int n,
                           input logic [15:0] ed, input logic eo, input logic en,
                           input string name);
    send(i, s0);
    if (n > 1) send(i, s1);
    if (n > 2) send(i, s2);
    if (n > 3) send(i, s3);
    collect(i, ed, eo, en, name);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid[i]  = 1'b0;
      in_data[i]   = 16'h0000;
      out_ready[i] = 1'b0;
    end
    #1;
    rst_n = 1'b0;
    #12;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (in_ready[i] !== 1'b1 || out_valid[i] !== 1'b0 || out_data[i] !== 16'h0000 ||
          out_ovf[i] !== 1'b0 || out_nan[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset inst=%0d: rdy=%b vld=%b data=%h ovf=%b nan=%b, required 1 0 0000 0 0",
                 i, in_ready[i], out_valid[i], out_data[i], out_ovf[i], out_nan[i]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic_latency();
    send(0, 16'h3C00);
    send(0, 16'h3C00);
    send(0, 16'h3C00);
    send(0, 16'h3C00);
    // One cycle after the accept edge: align stage.
    checks++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b0) begin
      errors++;
      $display("FAIL lat_align: valid=%b ready=%b, required 0 0", out_valid[0], in_ready[0]);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL lat_add: valid=%b, required 0", out_valid[0]);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid[0] !== 1'b1 || out_data[0] !== 16'h4400) begin
      errors++;
      $display("FAIL lat_done: valid=%b data=%h, required 1 4400", out_valid[0], out_data[0]);
    end
    collect(0, 16'h4400, 1'b0, 1'b0, "sum4_ones");
  endtask

  task automatic test_rounding();
    run_frame(1, 16'h6800, 16'h3C00, 16'h0, 16'h0, 2, 16'h6800, 1'b0, 1'b0, "tie_even_down");
    run_frame(1, 16'h6800, 16'h4200, 16'h0, 16'h0, 2, 16'h6802, 1'b0, 1'b0, "tie_even_up");
    run_frame(1, 16'h0001, 16'h0001, 16'h0, 16'h0, 2, 16'h0002, 1'b0, 1'b0, "denorm_add");
    run_frame(1, 16'h03FF, 16'h0001, 16'h0, 16'h0, 2, 16'h0400, 1'b0, 1'b0, "denorm_promote");
    run_frame(1, 16'hBC00, 16'h0000, 16'h0, 16'h0, 2, 16'h3C00, 1'b0, 1'b0, "sign_ignored");
  endtask

  task automatic test_overflow();
    run_frame(1, 16'h7BFF, 16'h7BFF, 16'h0, 16'h0, 2, 16'h7C00, 1'b1, 1'b0, "finite_ovf");
    run_frame(1, 16'h7C00, 16'h3C00, 16'h0, 16'h0, 2, 16'h7C00, 1'b0, 1'b0, "inf_input");
  endtask

  task automatic test_nan();
    run_frame(2, 16'h3C00, 16'h7E01, 16'h7C00, 16'h0, 3, 16'h7E00, 1'b0, 1'b1, "nan_sticky");
  endtask

  task automatic test_backpressure();
    int n;
    send(1, 16'h3C00);
    send(1, 16'h3C00);
    n = 0;
    @(negedge clk);
    while (!out_valid[1] && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL bp_valid: out_valid=%b, required 1", out_valid[1]);
    end
    // Input offered during DONE must be ignored.
    in_valid[1] = 1'b1;
    in_data[1]  = 16'h4000;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid[1] !== 1'b1 || out_data[1] !== 16'h4000 || in_ready[1] !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d: valid=%b data=%h ready=%b, required 1 4000 0",
                 c, out_valid[1], out_data[1], in_ready[1]);
      end
    end
    out_ready[1] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[1] = 1'b0;
    checks++;
    if (out_valid[1] !== 1'b0 || in_ready[1] !== 1'b1 || out_data[1] !== 16'h0000) begin
      errors++;
      $display("FAIL bp_release: valid=%b ready=%b data=%h, required 0 1 0000",
               out_valid[1], in_ready[1], out_data[1]);
    end
    in_valid[1] = 1'b0;
    in_data[1]  = 16'h0000;
    run_frame(1, 16'h3C00, 16'h4000, 16'h0, 16'h0, 2, 16'h4200, 1'b0, 1'b0, "after_bp");
  endtask

  task automatic test_reset_midframe();
    send(0, 16'h3C00);
    send(0, 16'h3C00);
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || out_data[0] !== 16'h0000 ||
        out_ovf[0] !== 1'b0 || out_nan[0] !== 1'b0) begin
      errors++;
      $display("FAIL midframe_reset: rdy=%b vld=%b data=%h ovf=%b nan=%b, required 1 0 0000 0 0",
               in_ready[0], out_valid[0], out_data[0], out_ovf[0], out_nan[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(0, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 4, 16'h4400, 1'b0, 1'b0, "post_reset");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic_latency();
    test_rounding();
    test_overflow();
    test_nan();
    test_backpressure();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

endmodule

// File: doc/fp16_sumsq_accumulator.md
Name: fp16_sumsq_accumulator

Overview:
- Downstream consumer of the FP16 squaring multiplier. It accumulates a frame of FRAME_LEN squared FP16 products into one FP16 sum-of-squares.
- All inputs are squares and therefore non-negative. Only same-sign addition is needed, so there is no cancellation and no left-normalisation.
- Inputs and output use valid/ready handshakes. The multiplier's registered output feeds in_data.

Parameters:
- FRAME_LEN, 4, number of accepted samples per output sum; legal range 1..65535.
- CNT_W, 16, width of the sample counter; must satisfy 2^CNT_W > FRAME_LEN.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_data is valid
- in_ready  output  1  block can accept a sample
- in_data  input  16  FP16 square; the sign bit is ignored (-0 is treated as +0)
- out_valid  output  1  frame sum available
- out_ready  input  1  downstream accepts the sum
- out_data  output  16  FP16 sum of squares
- out_ovf  output  1  frame overflowed to +Inf through finite addition
- out_nan  output  1  frame contained a NaN input

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, acc=16'h0000, count=0, sticky flags cleared.
  - Outputs: in_ready=1, out_valid=0, out_data=16'h0000, out_ovf=0, out_nan=0.
- FSM states: IDLE, ALIGN, ADD, DONE.
  - IDLE: in_ready=1. A handshake in_valid&in_ready latches the operand and moves to ALIGN.
  - ALIGN: in_ready=0. Selects L/S by magnitude, computing alignment into registers.
  - ADD: in_ready=0. Add, normalise, round, write acc, count++. If count was FRAME_LEN-1, go to DONE; otherwise go to IDLE.
  - DONE: out_valid=1, in_ready=0, and out_data/out_ovf/out_nan are held stable. When out_ready=1: clear acc, count and flags, then go to IDLE. out_valid deasserts the next cycle.
- Timing:
  - Sample accepted at edge T: acc is updated at edge T+2 and in_ready is high again in cycle T+3. Throughput is 1 sample per 3 cycles.
  - The last sample is accepted at T: out_valid is high from cycle T+3.
  - out_valid must not drop without out_ready.
- Arithmetic per sample:
  - Operands are the incoming sample and acc.
  - Effective exponent: e = exp, or 1 if exp==0. Significand: {exp!=0, mant}, 11 bits.
  - L is the operand with the larger {exp,mant}; S is the other.
  - d = eL - eS. Shift S right by d into a 14-bit field (11 bits + G,R,S), OR-ing shifted-out bits into sticky. If d >= 14, S collapses to sticky = (S!=0).
  - Add as a 12-bit sum. On carry-out: shift right 1 with sticky OR and increment the exponent.
  - If L is denormal and the sum sets bit 10, the result exponent is 1.
  - Round to nearest, ties to even. A mantissa overflow from rounding increments the exponent.
  - If the exponent reaches 31, the result is 16'h7C00 and the ovf sticky is set.
- Special values:
  - NaN input (exp=31, mant!=0): acc becomes 16'h7E00 and the nan sticky is set. acc stays 16'h7E00 for the rest of the frame.
  - Inf input: acc becomes 16'h7C00 unless it is already NaN. out_ovf is not set.
  - Once acc is Inf it stays Inf, except that a later NaN converts it to NaN.
- Boundaries:
  - FRAME_LEN=1: every sample produces a sum equal to the sample with its sign cleared.
  - in_valid is ignored outside IDLE.
  - out_ready is ignored outside DONE.
  - rst_n asserted mid-frame or in DONE discards everything immediately, with no partial output.
  - in_valid and out_ready may be high simultaneously in DONE; only the output handshake occurs.

Decomposition:
- Shared package fp16_pkg:
  - FP16 field widths: EXP_W=5, MAN_W=10, BIAS=15.
  - Constants: FP16_POS_INF=16'h7C00, FP16_QNAN=16'h7E00, FP16_ZERO=16'h0000.
  - FSM state enum.
- Sub-module fp16_nonneg_add_core: the combinational align/add/normalise/round datapath, split at the ALIGN/ADD register boundary via its stage outputs. The accumulator holds the FSM, counter, flags and handshakes.

Test Plan:
- FRAME_LEN=4, inputs 3C00,3C00,3C00,3C00 -> out_data=4400, ovf=0, nan=0. out_valid rises 3 cycles after the 4th accept.
- FRAME_LEN=2 frames:
  - (6800,3C00) -> 6800, the tie rounded to even.
  - (6800,4200) -> 6802.
  - (0001,0001) -> 0002.
  - (03FF,0001) -> 0400, denormal promoting to normal.
- FRAME_LEN=2, (7BFF,7BFF) -> 7C00 with out_ovf=1.
- FRAME_LEN=3, (3C00,7E01,7C00) -> 7E00 with out_nan=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid and out_data stay stable and in_ready=0. Then set out_ready=1 -> next frame starts from 0000.
- Reset mid-frame after 2 of 4 samples -> all outputs return to reset values immediately. The next 4 samples of 3C00 give 4400.
